// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bundle: ID-side request, memory/branch status
// and the stall, bubble, freeze and shadow-slot outputs.
interface hazard_scoreboard_if #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int CW    = 16
);
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_uses_rs1;
  logic          id_uses_rs2;
  logic [AW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_is_load;
  logic          mem_ready;
  logic          branch_taken;

  logic             stall_if_id;
  logic             bubble_ex;
  logic             freeze_all;
  logic [NREGS-1:0] busy_mask;
  logic [AW-1:0]    ex_rd;
  logic             ex_regwrite;
  logic             ex_is_load;
  logic [CW-1:0]    hazard_count;
  logic             stall_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output id_rd, id_regwrite, id_is_load,
    output mem_ready, branch_taken,
    input  stall_if_id, bubble_ex, freeze_all,
    input  busy_mask, ex_rd, ex_regwrite,
    input  ex_is_load, hazard_count, stall_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  id_rd, id_regwrite, id_is_load,
    input  mem_ready, branch_taken,
    output stall_if_id, bubble_ex, freeze_all,
    output busy_mask, ex_rd, ex_regwrite,
    output ex_is_load, hazard_count, stall_timeout
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shadow EX/MEM/WB write tracking, load-use / memory-wait / branch
// hazard arbitration, busy-register mask and stall statistics.
module hazard_scoreboard #(
  parameter int NREGS   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  hazard_scoreboard_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          is_load;
  } slot_t;

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;

  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] hc_q, hc_d;
  logic          to_q, to_d;

  logic lu, take_lu;
  logic stall, bubble, freeze;
  logic mr, br;
  logic [NREGS-1:0] busy;

  assign mr = bus.mem_ready;
  assign br = bus.branch_taken;

  assign lu = bus.id_valid & ex_q.valid & ex_q.is_load
            & ex_q.regwrite & (ex_q.rd != '0)
            & ((bus.id_uses_rs1 & (bus.id_rs1 == ex_q.rd))
             | (bus.id_uses_rs2 & (bus.id_rs2 == ex_q.rd)));

  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b0;
    freeze  = 1'b0;
    take_lu = 1'b0;
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    unique case (1'b1)
      !mr: begin
        freeze = 1'b1;
        stall  = 1'b1;
      end
      mr & br: begin
        bubble = 1'b1;
        ex_d   = '0;
      end
      mr & !br & lu: begin
        stall   = 1'b1;
        bubble  = 1'b1;
        take_lu = 1'b1;
        ex_d    = '0;
      end
      default: begin
        ex_d = '{valid:    bus.id_valid,
                 rd:       bus.id_rd,
                 regwrite: bus.id_regwrite,
                 is_load:  bus.id_is_load};
      end
    endcase
    if (mr) begin
      mem_d = ex_q;
      wb_d  = mem_q;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (mr)
      wait_d = '0;
    else if (wait_q != WW'(TIMEOUT))
      wait_d = wait_q + 1'b1;
    to_d = to_q | (wait_d == WW'(TIMEOUT));
    hc_d = hc_q;
    if (take_lu && hc_q != '1)
      hc_d = hc_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      wait_q <= '0;
      hc_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      wait_q <= wait_d;
      hc_q   <= hc_d;
      to_q   <= to_d;
    end
  end

  function automatic logic hit(slot_t s, int i);
    return s.valid & s.regwrite & (s.rd == AW'(i));
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 1; i < NREGS; i++)
      busy[i] = hit(ex_q, i) | hit(mem_q, i) | hit(wb_q, i);
  end

  // Reset silences the hazard strobes even while mem_ready is low.
  assign bus.stall_if_id   = stall & rst_ni;
  assign bus.bubble_ex     = bubble & rst_ni;
  assign bus.freeze_all    = freeze & rst_ni;
  assign bus.busy_mask     = busy;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_regwrite   = ex_q.valid & ex_q.regwrite;
  assign bus.ex_is_load    = ex_q.is_load;
  assign bus.hazard_count  = hc_q;
  assign bus.stall_timeout = to_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, forwarding,
// memory wait, watchdog, branch priority and async reset.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard_if #(.NREGS(8), .AW(3), .CW(16)) bus ();

  hazard_scoreboard #(
    .NREGS(8), .AW(3), .TIMEOUT(16), .CW(16)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [2:0] rs1,
                       input logic [2:0] rs2,
                       input logic u1, input logic u2,
                       input logic [2:0] rd,
                       input logic rw, input logic ld,
                       input logic mr, input logic br);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_uses_rs1  = u1;
    bus.id_uses_rs2  = u2;
    bus.id_rd        = rd;
    bus.id_regwrite  = rw;
    bus.id_is_load   = ld;
    bus.mem_ready    = mr;
    bus.branch_taken = br;
    #1;
  endtask

  task automatic idle(input logic mr);
    drive(0, 0, 0, 0, 0, 0, 0, 0, mr, 0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1);
    #11;
    check("rst_stall", bus.stall_if_id, 0);
    check("rst_bubble", bus.bubble_ex, 0);
    check("rst_freeze", bus.freeze_all, 0);
    check("rst_busy", bus.busy_mask, 0);
    check("rst_ex_rd", bus.ex_rd, 0);
    check("rst_ex_rw", bus.ex_regwrite, 0);
    check("rst_ex_ld", bus.ex_is_load, 0);
    check("rst_hc", bus.hazard_count, 0);
    check("rst_to", bus.stall_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // load-use on r3
    drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 0);
    check("lu_ld_stall", bus.stall_if_id, 0);
    tick();
    drive(1, 3, 0, 1, 0, 4, 1, 0, 1, 0);
    check("lu_stall", bus.stall_if_id, 1);
    check("lu_bubble", bus.bubble_ex, 1);
    check("lu_ex_ld", bus.ex_is_load, 1);
    check("lu_busy0", bus.busy_mask, 8'h08);
    tick();
    check("lu_stall2", bus.stall_if_id, 0);
    check("lu_bubble2", bus.bubble_ex, 0);
    check("lu_hc", bus.hazard_count, 1);
    check("lu_busy1", bus.busy_mask, 8'h08);
    check("lu_ex_rw", bus.ex_regwrite, 0);
    tick();
    check("lu_busy2", bus.busy_mask, 8'h18);
    check("lu_ex_rd", bus.ex_rd, 4);
    idle(1);
    repeat (3) tick();
    check("drain_busy", bus.busy_mask, 0);

    // forwardable producers
    drive(1, 0, 0, 0, 0, 3, 1, 0, 1, 0);
    tick();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    check("alu_stall", bus.stall_if_id, 0);
    check("alu_bubble", bus.bubble_ex, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    check("r0_stall", bus.stall_if_id, 0);
    check("r0_bubble", bus.bubble_ex, 0);
    check("r0_busy", bus.busy_mask, 8'h08);
    tick();
    check("fw_hc", bus.hazard_count, 1);
    idle(1);
    repeat (3) tick();

    // memory wait, short
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1, 0);
    tick();
    idle(0);
    for (int k = 0; k < 3; k++) begin
      check("mw_freeze", bus.freeze_all, 1);
      check("mw_stall", bus.stall_if_id, 1);
      check("mw_bubble", bus.bubble_ex, 0);
      check("mw_busy", bus.busy_mask, 8'h20);
      check("mw_ex_rd", bus.ex_rd, 5);
      tick();
    end
    idle(1);
    check("mw_freeze_off", bus.freeze_all, 0);
    check("mw_to", bus.stall_timeout, 0);
    tick();

    // memory wait, watchdog
    idle(0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      check($sformatf("to_%0d", k), bus.stall_timeout,
            (k >= 16) ? 32'd1 : 32'd0);
    end
    idle(1);
    tick();
    check("to_sticky", bus.stall_timeout, 1);
    repeat (3) tick();

    // branch beats load-use
    drive(1, 0, 0, 0, 0, 2, 1, 1, 1, 0);
    tick();
    drive(1, 0, 2, 0, 1, 4, 1, 0, 1, 1);
    check("br_stall", bus.stall_if_id, 0);
    check("br_bubble", bus.bubble_ex, 1);
    check("br_freeze", bus.freeze_all, 0);
    tick();
    idle(1);
    check("br_ex_rw", bus.ex_regwrite, 0);
    check("br_ex_ld", bus.ex_is_load, 0);
    check("br_hc", bus.hazard_count, 1);
    repeat (3) tick();

    // async reset during a freeze
    drive(1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 6, 1, 1, 1, 0);
    tick();
    idle(0);
    check("rs_busy_pre", bus.busy_mask, 8'h46);
    check("rs_freeze_pre", bus.freeze_all, 1);
    rst_n = 1'b0;
    #1;
    check("rs_busy", bus.busy_mask, 0);
    check("rs_freeze", bus.freeze_all, 0);
    check("rs_stall", bus.stall_if_id, 0);
    check("rs_ex_rd", bus.ex_rd, 0);
    check("rs_ex_rw", bus.ex_regwrite, 0);
    check("rs_ex_ld", bus.ex_is_load, 0);
    idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rs_hc", bus.hazard_count, 0);
    check("rs_to", bus.stall_timeout, 0);
    drive(1, 6, 0, 1, 0, 0, 0, 0, 1, 0);
    check("rs_first_stall", bus.stall_if_id, 0);
    check("rs_first_bubble", bus.bubble_ex, 0);
    tick();
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage operand forwarding logic in the RISC-8 pipeline.
- Tracks every in-flight register write in shadow EX/MEM/WB slots and exports the busy-register mask.
- Detects hazards that forwarding cannot cover: load-use, memory wait and branch flush.
- Drives the IF/ID stall, the ID/EX bubble insert and the global pipeline freeze.

Parameters:
- NREGS, 8, number of architectural registers; r0 is hardwired zero.
- AW, 3, register address width.
- TIMEOUT, 16, consecutive mem_ready-low cycles before stall_timeout is set.
- CW, 16, width of the hazard performance counter.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  reset; asynchronous, active-low.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs1  input  AW  ID source 1.
- id_rs2  input  AW  ID source 2.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_rd  input  AW  ID destination.
- id_regwrite  input  1  ID instruction writes rd.
- id_is_load  input  1  ID instruction is a load.
- mem_ready  input  1  data memory completes this cycle; 0 = wait.
- branch_taken  input  1  EX resolved a taken branch; the ID instruction is discarded.
- stall_if_id  output  1  hold PC and IF/ID register.
- bubble_ex  output  1  load NOP into ID/EX.
- freeze_all  output  1  hold all pipeline registers.
- busy_mask  output  NREGS  bit i = pending write to register i.
- ex_rd  output  AW  shadow EX destination.
- ex_regwrite  output  1  shadow EX write enable, qualified by slot valid.
- ex_is_load  output  1  shadow EX load flag.
- hazard_count  output  CW  saturating count of load-use stall cycles.
- stall_timeout  output  1  sticky memory-wait watchdog flag.

Behaviour:
- State:
  - Three shadow slots EX, MEM and WB, each holding {valid, rd, regwrite, is_load}.
  - Wait counter, hazard_count and the stall_timeout flag.
- Reset (rst_n=0, asynchronous):
  - All slot fields cleared.
  - Wait counter, hazard_count and stall_timeout = 0.
  - Resulting outputs: stall_if_id=0, bubble_ex=0, freeze_all=0, busy_mask=0, ex_rd=0, ex_regwrite=0, ex_is_load=0.
- Hazard terms, combinational in the same cycle from ID inputs and EX slot state:
  - lu = id_valid & EX.valid & EX.is_load & EX.regwrite & (EX.rd!=0) & ((id_uses_rs1 & id_rs1==EX.rd) | (id_uses_rs2 & id_rs2==EX.rd)).
  - A non-load producer in EX/MEM/WB never causes a stall; forwarding resolves it.
- Priority, highest first:
  1. mem_ready=0:
     - freeze_all=1, stall_if_id=1, bubble_ex=0.
     - All slots hold; branch_taken and lu are ignored.
  2. branch_taken=1:
     - stall_if_id=0, bubble_ex=1.
     - The next EX slot gets valid=0, even if lu=1.
  3. lu=1:
     - stall_if_id=1, bubble_ex=1.
     - The next EX slot gets valid=0; the ID instruction is re-presented next cycle.
  4. Otherwise:
     - All three outputs are 0.
     - The next EX slot gets {id_valid, id_rd, id_regwrite, id_is_load}.
- Slot advance: when mem_ready=1, MEM<=EX and WB<=MEM on every edge. The WB slot retires after one cycle.
- A registered load-use stall lasts exactly one cycle per load. The next cycle, the load is in MEM and is forwardable.
- busy_mask:
  - Bit i = OR over slots of (valid & regwrite & rd==i), for i!=0.
  - Bit 0 is always 0.
  - Decoded from registers; glitch-free relative to the clock.
- ex_* outputs are taken directly from the EX slot, with ex_regwrite ANDed with valid.
- hazard_count:
  - +1 on each edge where lu=1 wins arbitration (priority 3).
  - Saturates at 2^CW-1; no wrap.
- Wait counter and stall_timeout:
  - The wait counter increments on each edge with mem_ready=0, saturating at TIMEOUT, and clears to 0 on an edge with mem_ready=1.
  - stall_timeout is set on the edge at which the counter reaches TIMEOUT, i.e. the end of the TIMEOUT-th consecutive low cycle.
  - stall_timeout stays set until reset.
- Simultaneous freeze and writeback: the WB slot holds during a freeze; the register-file write is repeated, and that is harmless.
- Reset asserted mid-freeze or mid-stall: the shadow is emptied immediately. The first instruction after release issues without a stall.

Test Plan:
1. Load-use stall:
   - Stimulus: load r3 issued, next cycle ID = add using rs1=r3 with mem_ready=1.
   - Response: that cycle stall_if_id=1 and bubble_ex=1.
   - Next cycle: both 0, MEM.rd=3, hazard_count=1, busy_mask=8'b0000_1000.
2. Forwardable producers:
   - Stimulus: ALU write to r3, then a consumer of r3. Separately, load r0, then a consumer of r0.
   - Response: stall_if_id=0 and bubble_ex=0 in both cases; hazard_count unchanged.
3. Memory wait, no timeout:
   - Stimulus: mem_ready=0 for 3 cycles with TIMEOUT=16.
   - Response: freeze_all=1 and stall_if_id=1 for 3 cycles.
   - busy_mask and ex_rd unchanged; stall_timeout=0; the wait counter returns to 0 after mem_ready rises.
4. Memory wait, timeout:
   - Stimulus: mem_ready=0 for 17 cycles.
   - Response: stall_timeout=1 after the 16th low edge, and it remains 1 after mem_ready returns.
5. Branch beats load-use:
   - Stimulus: branch_taken=1 in the same cycle as lu=1.
   - Response: stall_if_id=0, bubble_ex=1, hazard_count not incremented; the EX slot is invalid next cycle.
6. Reset mid-operation:
   - Stimulus: rst_n pulsed low during a freeze with three valid slots.
   - Response: the outputs go to their reset values immediately, without a clock edge (busy_mask=0, freeze_all=0, ex_rd=0, ex_regwrite=0, ex_is_load=0).
   - After release, hazard_count=0 and stall_timeout=0.
